ram_march_master: RTL

- Initiator-side block that drives the single-port RAM interface of the memory blocks in this design: write enable, read enable, address, and a shared bidirectional data bus.
- On a start pulse it writes a seed-derived pattern to every word, reads every word back, compares it, and reports pass/fail with error statistics.
- Used as power-on memory self-test and as the bench-side driver for RAM blocks.

---
 rtl/ram_march_master.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ram_march_master.sv
// ram_march_master: write/read-back self test over a single-port RAM.
// Writes P(a) = seed + a to every word, reads each word back one at a time,
// compares it and reports pass/fail, the mismatch count and the first bad address.
//
// Run protocol: start is a level sampled only while idle. The cycle after it
// is accepted, busy rises and stays high until the DONE cycle. done is a
// one-cycle pulse in that DONE cycle, and the result outputs are held from
// then until the next accepted start.
module ram_march_master #(
  parameter int WORD_SIZE    = 8,
  parameter int DEPTH        = 32,
  parameter int ADDR_W       = 5,   // DEPTH must not exceed 2**ADDR_W
  parameter int READ_LATENCY = 1    // >= 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] seed,
  output logic                 we,
  output logic                 re,
  output logic [ADDR_W-1:0]    addr,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_W:0]      err_count,
  output logic [ADDR_W-1:0]    first_err_addr,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_TURN  = 3'd2,
    S_READ  = 3'd3,
    S_WAIT  = 3'd4,
    S_CMP   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // The wait counter runs from READ_LATENCY-1 down to 0.
  localparam int                WAIT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY - 1);

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      a_q, a_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [WORD_SIZE-1:0]   seed_q, seed_d;
  logic [WORD_SIZE-1:0]   rd_q, rd_d;
  logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
  logic [ADDR_W:0]        err_q, err_d;
  logic [ADDR_W-1:0]      first_q, first_d;
  logic                   pass_q, pass_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   we_q, we_d;
  logic                   re_q, re_d;
  logic                   mismatch;

  // Test pattern: seed plus zero-extended address, wrapping at the word width.
  function automatic logic [WORD_SIZE-1:0] pattern(input logic [WORD_SIZE-1:0] s,
                                                   input logic [ADDR_W-1:0]    a);
    return s + WORD_SIZE'(a);
  endfunction

  // Case-equality so that any unknown or floating bit read back counts as an error.
  assign mismatch = (rd_q !== pattern(seed_q, a_q));

  // The bus is driven only in write cycles; every other cycle it is released.
  assign data = we_q ? wdata_q : {WORD_SIZE{1'bz}};

  assign we             = we_q;
  assign re             = re_q;
  assign addr           = a_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign state_dbg      = state_q;

  // Next-state, address/counter and result logic; outputs are derived from the next state
  // so that every RAM control output comes straight from a flop.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    wait_d  = wait_q;
    seed_d  = seed_q;
    rd_d    = rd_q;
    err_d   = err_q;
    first_d = first_q;
    pass_d  = pass_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          seed_d  = seed;
          err_d   = '0;
          first_d = '0;
          pass_d  = 1'b0;
          a_d     = '0;
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        if (a_q == LAST_ADDR) begin
          a_d     = '0;
          state_d = S_TURN;
        end else begin
          a_d = a_q + ADDR_W'(1);
        end
      end

      // One dead cycle so the RAM never sees our write data while it starts driving.
      S_TURN: begin
        state_d = S_READ;
      end

      S_READ: begin
        wait_d  = WAIT_LAST;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (wait_q == '0) begin
          rd_d    = data;
          state_d = S_CMP;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end

      S_CMP: begin
        if (mismatch) begin
          err_d = err_q + (ADDR_W + 1)'(1);
          if (err_q == '0) begin
            first_d = a_q;
          end
        end
        if (a_q == LAST_ADDR) begin
          pass_d  = (err_d == '0);
          state_d = S_DONE;
        end else begin
          a_d     = a_q + ADDR_W'(1);
          state_d = S_READ;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    we_d    = (state_d == S_WRITE);
    re_d    = (state_d == S_READ);
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d  = (state_d == S_DONE);
    wdata_d = pattern(seed_d, a_d);
  end

  // State and registered outputs; reset aborts a run and releases the bus immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      wait_q  <= '0;
      seed_q  <= '0;
      rd_q    <= '0;
      wdata_q <= '0;
      err_q   <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      wait_q  <= wait_d;
      seed_q  <= seed_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      first_q <= first_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      re_q    <= re_d;
    end
  end

endmodule
